// File: rtl/bitstream_pkg.sv
// Shared definitions for the LiDAR bitstream path.
//   BITSTREAM_W      : width of one bitstream word
//   bitstream_word_t : one bitstream word
//   DROP_CNT_W       : width of the optional dropped-push counter
package bitstream_pkg;

    localparam int BITSTREAM_W = 512;
    typedef logic [BITSTREAM_W-1:0] bitstream_word_t;
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/bitstream_fifo_if.sv
// Handshake bundle between the bitstream source, bitstream_fifo and the
// bitstream reader.
//   wr_en, bitstream_in          : push side (source -> fifo)
//   rd_en                        : pop request (reader -> fifo)
//   bitstream_out, out_valid     : head word (fifo -> reader)
//   empty, full, almost_full     : occupancy flags
//   level                        : occupancy count
//   overflow                     : sticky dropped-push flag
//   drop_cnt                     : dropped-push count, present only when
//                                  BITSTREAM_FIFO_DROP_CNT_EN is defined
// Modports: master = source/reader side, slave = fifo side.
interface bitstream_fifo_if
    import bitstream_pkg::*;
#(
    parameter int DATA_W = BITSTREAM_W,
    parameter int DEPTH  = 4
) ();

    logic                         wr_en;
    logic [DATA_W-1:0]            bitstream_in;
    logic                         rd_en;
    logic [DATA_W-1:0]            bitstream_out;
    logic                         out_valid;
    logic                         empty;
    logic                         full;
    logic                         almost_full;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         overflow;
`ifdef BITSTREAM_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0]        drop_cnt;
`endif

    modport master (
        output wr_en, bitstream_in, rd_en,
        input  bitstream_out, out_valid, empty, full, almost_full, level, overflow
`ifdef BITSTREAM_FIFO_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  wr_en, bitstream_in, rd_en,
        output bitstream_out, out_valid, empty, full, almost_full, level, overflow
`ifdef BITSTREAM_FIFO_DROP_CNT_EN
        , output drop_cnt
`endif
    );

endinterface

// File: rtl/bitstream_fifo_mem.sv
// Storage array for bitstream_fifo: DEPTH x DATA_W registers, no reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write slot
//   wr_data : word to store
//   rd_addr : read slot
//   rd_data : combinational read of mem[rd_addr]
module bitstream_fifo_mem #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bitstream_fifo.sv
// First-word-fall-through FIFO for LiDAR bitstream words.
// Optional feature macro: BITSTREAM_FIFO_DROP_CNT_EN adds a saturating
// 16-bit count of dropped pushes on bus.drop_cnt.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : bitstream_fifo_if.slave (push/pop handshake, head word, flags)
// A push and a pop are both accepted while full; the new word lands in the
// slot being freed. A push while full without a pop is dropped and sets the
// sticky overflow flag.
module bitstream_fifo
    import bitstream_pkg::*;
#(
    parameter int DATA_W       = BITSTREAM_W,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic               clk,
    input  logic               reset,
    bitstream_fifo_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("bitstream_fifo: DEPTH must be a power of two >= 2");
        end
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
            $error("bitstream_fifo: AFULL_THRESH must be in 1..DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q;
    logic [DATA_W-1:0] head_word;

    logic empty_w;
    logic full_w;
    logic rd_acc;
    logic wr_acc;
    logic drop_w;

    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == LVL_W'(DEPTH));
    assign rd_acc  = bus.rd_en && !empty_w;
    // Popping frees a slot this same edge, so a full FIFO can still take a push.
    assign wr_acc  = bus.wr_en && (!full_w || rd_acc);
    assign drop_w  = bus.wr_en && !wr_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - LVL_W'(1);
            end
            if (drop_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    bitstream_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !reset),
        .wr_addr (wr_ptr),
        .wr_data (bus.bitstream_in),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    // Stale storage must never leak out while empty.
    assign bus.bitstream_out = empty_w ? '0 : head_word;
    assign bus.out_valid     = !empty_w;
    assign bus.empty         = empty_w;
    assign bus.full          = full_w;
    assign bus.almost_full   = (level_q >= LVL_W'(AFULL_THRESH));
    assign bus.level         = level_q;
    assign bus.overflow      = overflow_q;

`ifdef BITSTREAM_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_w && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule
